// File: rtl/door_code_tx.sv
// door_code_tx
// Plays a 4-symbol button code into a door lock, one symbol per SEND state,
// separated by GAP_CYCLES idle cycles. It then waits up to TIMEOUT cycles for
// the lock's LED response and records a sticky outcome flag.
// One symbol can optionally be sent bit-inverted, so a bad code can be
// exercised deliberately.
module door_code_tx #(
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 8
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       start,
  input  logic [7:0] code,
  input  logic       inject_err,
  input  logic [1:0] err_pos,
  input  logic       LED_right,
  input  logic       LED_wrong,
  output logic [2:1] bn,
  output logic       bn_valid,
  output logic [1:0] tx_index,
  output logic       busy,
  output logic       done,
  output logic       result_ok,
  output logic       result_fail,
  output logic       result_timeout
);

  // FSM encoding, kept as plain constants so older tools and scripts can match on them
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SEND      = 3'd1;
  localparam logic [2:0] S_GAP       = 3'd2;
  localparam logic [2:0] S_WAIT_RESP = 3'd3;
  localparam logic [2:0] S_REPORT    = 3'd4;

  // Terminal counter values. GAP_LAST is never used when GAP_CYCLES is 0,
  // because SEND then loops straight back into SEND.
  localparam logic [3:0] GAP_LAST     = 4'(GAP_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  logic [2:0] r_state;
  logic [7:0] r_code;
  logic       r_injErr;
  logic [1:0] r_errPos;
  logic [1:0] r_txIndex;
  logic [3:0] r_gapCnt;
  logic [7:0] r_waitCnt;
  logic       r_resultOk;
  logic       r_resultFail;
  logic       r_resultTimeout;

  logic [1:0] w_symbol;
  logic [1:0] w_sendSymbol;

  // Transaction sequencing. Clear has priority over everything, including a start in the same cycle.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state         <= S_IDLE;
      r_code          <= 8'h00;
      r_injErr        <= 1'b0;
      r_errPos        <= 2'd0;
      r_txIndex       <= 2'd0;
      r_gapCnt        <= 4'd0;
      r_waitCnt       <= 8'd0;
      r_resultOk      <= 1'b0;
      r_resultFail    <= 1'b0;
      r_resultTimeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_code          <= code;
            r_injErr        <= inject_err;
            r_errPos        <= err_pos;
            r_txIndex       <= 2'd0;
            r_gapCnt        <= 4'd0;
            r_waitCnt       <= 8'd0;
            r_resultOk      <= 1'b0;
            r_resultFail    <= 1'b0;
            r_resultTimeout <= 1'b0;
            r_state         <= S_SEND;
          end
        end
        S_SEND: begin
          if (r_txIndex == 2'd3) begin
            r_waitCnt <= 8'd0;
            r_state   <= S_WAIT_RESP;
          end else begin
            r_txIndex <= r_txIndex + 2'd1;
            if (GAP_CYCLES == 0) begin
              r_state <= S_SEND;
            end else begin
              r_gapCnt <= 4'd0;
              r_state  <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (r_gapCnt == GAP_LAST) begin
            r_state <= S_SEND;
          end else begin
            r_gapCnt <= r_gapCnt + 4'd1;
          end
        end
        S_WAIT_RESP: begin
          if (LED_wrong) begin
            r_resultFail <= 1'b1;
            r_state      <= S_REPORT;
          end else if (LED_right) begin
            r_resultOk <= 1'b1;
            r_state    <= S_REPORT;
          end else if (r_waitCnt == TIMEOUT_LAST) begin
            r_resultTimeout <= 1'b1;
            r_state         <= S_REPORT;
          end else begin
            r_waitCnt <= r_waitCnt + 8'd1;
          end
        end
        S_REPORT: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Select the current symbol from the latched code, most significant pair first
  always_comb begin
    w_symbol = 2'b00;
    case (r_txIndex)
      2'd0:    w_symbol = r_code[7:6];
      2'd1:    w_symbol = r_code[5:4];
      2'd2:    w_symbol = r_code[3:2];
      default: w_symbol = r_code[1:0];
    endcase
  end

  // Apply the optional corruption and gate the button bus so it reads zero outside SEND
  always_comb begin
    w_sendSymbol = w_symbol;
    if (r_injErr && (r_txIndex == r_errPos)) begin
      w_sendSymbol = ~w_symbol;
    end
    bn       = (r_state == S_SEND) ? w_sendSymbol : 2'b00;
    bn_valid = (r_state == S_SEND);
  end

  assign tx_index       = r_txIndex;
  assign busy           = (r_state != S_IDLE);
  assign done           = (r_state == S_REPORT);
  assign result_ok      = r_resultOk;
  assign result_fail    = r_resultFail;
  assign result_timeout = r_resultTimeout;

endmodule

// File: tb/tb_door_code_tx.sv
// tb_door_code_tx
// Drives door_code_tx with directed and randomized transactions. The expected
// cycle-by-cycle behaviour is computed from the symbol timing rules:
// symbol k appears at cycle 1+k*(GAP+1), and the wait window follows the last symbol.
// Instance A uses GAP=2/TIMEOUT=8, instance B uses GAP=0/TIMEOUT=3.
module tb_door_code_tx;

  localparam int A_GAP = 2;
  localparam int A_TO  = 8;
  localparam int B_GAP = 0;
  localparam int B_TO  = 3;

  logic       clock = 1'b0;
  logic       clear;
  logic       startA, startB;
  logic [7:0] code;
  logic       injectErr;
  logic [1:0] errPos;
  logic       ledRight, ledWrong;

  logic [2:1] aBn, bBn;
  logic       aBnValid, bBnValid, aBusy, bBusy, aDone, bDone;
  logic [1:0] aTxIndex, bTxIndex;
  logic       aOk, bOk, aFail, bFail, aTimeout, bTimeout;

  int sel = 0;
  int checks = 0;
  int failures = 0;

  logic [1:0] obsBn, obsTx;
  logic       obsValid, obsBusy, obsDone;
  logic [2:0] obsFlags;

  // Observed outputs of whichever instance the current transaction targets
  assign obsBn    = (sel == 1) ? bBn : aBn;
  assign obsTx    = (sel == 1) ? bTxIndex : aTxIndex;
  assign obsValid = (sel == 1) ? bBnValid : aBnValid;
  assign obsBusy  = (sel == 1) ? bBusy : aBusy;
  assign obsDone  = (sel == 1) ? bDone : aDone;
  assign obsFlags = (sel == 1) ? {bOk, bFail, bTimeout} : {aOk, aFail, aTimeout};

  always #5 clock = ~clock;

  door_code_tx #(.GAP_CYCLES(A_GAP), .TIMEOUT(A_TO)) dutA (
    .clock(clock), .clear(clear), .start(startA), .code(code),
    .inject_err(injectErr), .err_pos(errPos),
    .LED_right(ledRight), .LED_wrong(ledWrong),
    .bn(aBn), .bn_valid(aBnValid), .tx_index(aTxIndex), .busy(aBusy), .done(aDone),
    .result_ok(aOk), .result_fail(aFail), .result_timeout(aTimeout)
  );

  door_code_tx #(.GAP_CYCLES(B_GAP), .TIMEOUT(B_TO)) dutB (
    .clock(clock), .clear(clear), .start(startB), .code(code),
    .inject_err(injectErr), .err_pos(errPos),
    .LED_right(ledRight), .LED_wrong(ledWrong),
    .bn(bBn), .bn_valid(bBnValid), .tx_index(bTxIndex), .busy(bBusy), .done(bDone),
    .result_ok(bOk), .result_fail(bFail), .result_timeout(bTimeout)
  );

  // Runs one transaction from an idle negedge and checks every cycle against the
  // timing model. rightAt/wrongAt pick the wait-window cycle where an LED fires (-1 = never).
  // noise: 0 = quiet, 1 = LED noise outside the window, 2 = noise everywhere plus stray starts.
  task automatic runTxn(input int dut, input logic [7:0] txCode, input bit inj,
                        input logic [1:0] pos, input int rightAt, input int wrongAt,
                        input int noise, input bit hold);
    int g, to, w, r, sendK;
    logic [1:0] sym[4];
    logic [2:0] outFlags, expFlags;
    logic [1:0] expBn, expTx;
    logic stv;
    bit expR[64];
    bit expW[64];
    bit inWin;
    g  = (dut == 1) ? B_GAP : A_GAP;
    to = (dut == 1) ? B_TO : A_TO;
    w  = 3 * (g + 1) + 2;
    for (int cc = 0; cc < 64; cc++) begin
      inWin = (cc >= w) && (cc < w + to);
      if (inWin) begin
        expR[cc] = (cc - w == rightAt) || (noise == 2 && $urandom_range(0, 5) == 0);
        expW[cc] = (cc - w == wrongAt) || (noise == 2 && $urandom_range(0, 7) == 0);
      end else begin
        expR[cc] = (noise > 0) && ($urandom_range(0, 2) == 0);
        expW[cc] = (noise > 0) && ($urandom_range(0, 2) == 0);
      end
    end
    expR[0] = 1'b0;
    expW[0] = 1'b0;
    r = 0;
    outFlags = 3'b000;
    for (int j = 0; j < to && r == 0; j++) begin
      if (expW[w + j]) begin
        outFlags = 3'b010; r = w + j + 1;
      end else if (expR[w + j]) begin
        outFlags = 3'b100; r = w + j + 1;
      end else if (j == to - 1) begin
        outFlags = 3'b001; r = w + j + 1;
      end
    end
    for (int k = 0; k < 4; k++) begin
      sym[k] = 2'((txCode >> (6 - 2 * k)) & 8'h03);
      if (inj && int'(pos) == k) sym[k] = ~sym[k];
    end

    sel = dut;
    code = txCode; injectErr = inj; errPos = pos;
    ledRight = 1'b0; ledWrong = 1'b0;
    if (dut == 1) startB = 1'b1; else startA = 1'b1;
    @(posedge clock);
    for (int cc = 1; cc <= r; cc++) begin
      @(negedge clock);
      sendK = -1;
      for (int k = 0; k < 4; k++) if (cc == 1 + k * (g + 1)) sendK = k;
      expBn = (sendK >= 0) ? sym[sendK] : 2'b00;
      expFlags = (cc == r) ? outFlags : 3'b000;
      checks++;
      if (obsBusy !== 1'b1) begin
        failures++; $display("[TB] FAIL busy dut=%0d c=%0d got %b want 1", dut, cc, obsBusy);
      end
      checks++;
      if (obsValid !== (sendK >= 0)) begin
        failures++; $display("[TB] FAIL bn_valid dut=%0d c=%0d got %b want %b", dut, cc, obsValid, sendK >= 0);
      end
      checks++;
      if (obsBn !== expBn) begin
        failures++; $display("[TB] FAIL bn dut=%0d c=%0d got %b want %b", dut, cc, obsBn, expBn);
      end
      checks++;
      if (obsDone !== (cc == r)) begin
        failures++; $display("[TB] FAIL done dut=%0d c=%0d got %b want %b", dut, cc, obsDone, cc == r);
      end
      checks++;
      if (obsFlags !== expFlags) begin
        failures++; $display("[TB] FAIL flags dut=%0d c=%0d got %b want %b", dut, cc, obsFlags, expFlags);
      end
      if (sendK >= 0 || cc >= w) begin
        expTx = (sendK >= 0) ? 2'(sendK) : 2'd3;
        checks++;
        if (obsTx !== expTx) begin
          failures++; $display("[TB] FAIL tx_index dut=%0d c=%0d got %0d want %0d", dut, cc, obsTx, expTx);
        end
      end
      code = 8'($urandom); injectErr = 1'($urandom); errPos = 2'($urandom);
      stv = hold || (noise == 2 && $urandom_range(0, 3) == 0);
      if (dut == 1) startB = stv; else startA = stv;
      ledRight = expR[cc]; ledWrong = expW[cc];
    end
    @(negedge clock);
    checks++;
    if ({obsBusy, obsDone, obsValid, obsBn} !== 5'b0) begin
      failures++; $display("[TB] FAIL idle_after dut=%0d got busy/done/valid/bn %b want 00000", dut, {obsBusy, obsDone, obsValid, obsBn});
    end
    checks++;
    if (obsFlags !== outFlags || obsTx !== 2'd3) begin
      failures++; $display("[TB] FAIL hold_after dut=%0d got flags %b tx %0d want %b tx 3", dut, obsFlags, obsTx, outFlags);
    end
    ledRight = 1'b0; ledWrong = 1'b0;
    if (dut == 1) startB = hold; else startA = hold;
    if (!hold) begin
      @(negedge clock);
      checks++;
      if (obsBusy !== 1'b0 || obsFlags !== outFlags) begin
        failures++; $display("[TB] FAIL no_queue dut=%0d got busy %b flags %b want 0 %b", dut, obsBusy, obsFlags, outFlags);
      end
    end
  endtask

  // Reset values on both instances, with a start and LED activity held during clear
  task automatic test_reset;
    clear = 1'b1; startA = 1'b1; startB = 1'b1;
    code = 8'hFF; injectErr = 1'b1; errPos = 2'd3; ledRight = 1'b1; ledWrong = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({aBn, aBnValid, aTxIndex, aBusy, aDone, aOk, aFail, aTimeout} !== 10'b0) begin
      failures++; $display("[TB] FAIL reset_a got %b want 0", {aBn, aBnValid, aTxIndex, aBusy, aDone, aOk, aFail, aTimeout});
    end
    checks++;
    if ({bBn, bBnValid, bTxIndex, bBusy, bDone, bOk, bFail, bTimeout} !== 10'b0) begin
      failures++; $display("[TB] FAIL reset_b got %b want 0", {bBn, bBnValid, bTxIndex, bBusy, bDone, bOk, bFail, bTimeout});
    end
    clear = 1'b0; startA = 1'b0; startB = 1'b0; ledRight = 1'b0; ledWrong = 1'b0;
    @(negedge clock);
    checks++;
    if (aBusy !== 1'b0 || bBusy !== 1'b0) begin
      failures++; $display("[TB] FAIL start_with_clear got busy %b%b want 00", aBusy, bBusy);
    end
  endtask

  // Clear issued in the gap after symbol 1 (with a coincident start), then a fresh code
  task automatic test_clear_mid_gap;
    sel = 0;
    code = 8'h9C; injectErr = 1'b0; errPos = 2'd0; startA = 1'b1;
    @(posedge clock);
    for (int cc = 1; cc <= 5; cc++) begin
      @(negedge clock);
      startA = 1'b0;
    end
    checks++;
    if (aBusy !== 1'b1 || aBnValid !== 1'b0 || aBn !== 2'b00) begin
      failures++; $display("[TB] FAIL gap_state got busy %b valid %b bn %b want 1 0 00", aBusy, aBnValid, aBn);
    end
    clear = 1'b1; startA = 1'b1;
    @(negedge clock);
    checks++;
    if ({aBn, aBnValid, aTxIndex, aBusy, aDone, aOk, aFail, aTimeout} !== 10'b0) begin
      failures++; $display("[TB] FAIL clear_mid_gap got %b want 0", {aBn, aBnValid, aTxIndex, aBusy, aDone, aOk, aFail, aTimeout});
    end
    clear = 1'b0; startA = 1'b0;
    @(negedge clock);
    checks++;
    if (aBusy !== 1'b0) begin
      failures++; $display("[TB] FAIL clear_start_ignored got busy %b want 0", aBusy);
    end
  endtask

  // Ordered scenario list, ending in the single summary line
  initial begin
    clear = 1'b1; startA = 1'b0; startB = 1'b0; code = 8'h00;
    injectErr = 1'b0; errPos = 2'd0; ledRight = 1'b0; ledWrong = 1'b0;
    test_reset;
    $display("[TB] nominal code with right response");
    runTxn(0, 8'b10_01_11_00, 1'b0, 2'd0, 2, -1, 0, 1'b0);
    $display("[TB] injected error with wrong response");
    runTxn(0, 8'hE4, 1'b1, 2'd2, -1, 0, 0, 1'b0);
    $display("[TB] timeout with LED noise outside the window");
    runTxn(0, 8'b10_01_11_00, 1'b0, 2'd0, -1, -1, 1, 1'b0);
    $display("[TB] both LEDs together");
    runTxn(0, 8'h5A, 1'b0, 2'd0, 3, 3, 0, 1'b0);
    $display("[TB] zero gap instance");
    runTxn(1, 8'b00_11_01_10, 1'b0, 2'd0, 1, -1, 0, 1'b0);
    runTxn(1, 8'h3C, 1'b1, 2'd0, -1, -1, 0, 1'b0);
    $display("[TB] stray starts while busy");
    runTxn(0, 8'h71, 1'b1, 2'd3, -1, -1, 2, 1'b0);
    $display("[TB] start held high across back-to-back transactions");
    runTxn(0, 8'hC6, 1'b0, 2'd0, 0, -1, 0, 1'b1);
    runTxn(0, 8'h2B, 1'b1, 2'd1, -1, 4, 0, 1'b0);
    $display("[TB] randomized transactions");
    for (int i = 0; i < 16; i++) begin
      runTxn(int'($urandom_range(0, 1)), 8'($urandom), 1'($urandom), 2'($urandom), -1, -1, 2, 1'b0);
    end
    $display("[TB] clear during gap");
    test_clear_mid_gap;
    runTxn(0, 8'hB4, 1'b0, 2'd0, 5, -1, 0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
